car_light_scheduler: RTL

- Arbitrates lighting requests from the manual-drive and auto-drive controllers and produces the registered `stay` / `twinkle_left` / `twinkle_right` command triple for the car LED driver.
- Applies power gating, brake priority and left/right conflict rejection.
- Enforces a minimum turn-signal blink duration after a turn request drops.
- Sits between the driving-mode logic and the LED driver, in the same clock domain.

---
 rtl/car_light_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/car_light_scheduler.sv
// Car light command scheduler: arbitrates manual/auto lighting requests into a
// registered stay/twinkle_left/twinkle_right triple with brake priority and turn hold.
module car_light_scheduler #(
    parameter int unsigned HOLD_TICKS = 900,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       power_on,
    input  logic       auto_mode,
    input  logic       man_left,
    input  logic       man_right,
    input  logic       man_brake,
    input  logic       auto_left,
    input  logic       auto_right,
    input  logic       auto_brake,
    output logic       stay,
    output logic       twinkle_left,
    output logic       twinkle_right,
    output logic [2:0] state_o
);

    // state | meaning
    // OFF   | power gated, all lights off
    // IDLE  | powered, no request active
    // BRAKE | brake request, both lights steady
    // LEFT  | left turn requested or holding
    // RIGHT | right turn requested or holding
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_BRAKE = 3'd2,
        ST_LEFT  = 3'd3,
        ST_RIGHT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             r_mode_q;
    logic [2:0]       r_out;
    logic [2:0]       w_out_nxt;

    logic w_sel_left;
    logic w_sel_right;
    logic w_sel_brake;
    logic w_req_l;
    logic w_req_r;
    logic w_mode_chg;
    logic w_in_turn;

    assign w_sel_left  = auto_mode ? auto_left  : man_left;
    assign w_sel_right = auto_mode ? auto_right : man_right;
    assign w_sel_brake = auto_mode ? auto_brake : man_brake;
    // Simultaneous left and right is treated as no turn request at all.
    assign w_req_l     = w_sel_left  & ~w_sel_right;
    assign w_req_r     = w_sel_right & ~w_sel_left;
    assign w_mode_chg  = (auto_mode != r_mode_q);
    assign w_in_turn   = (r_state == ST_LEFT) || (r_state == ST_RIGHT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_hold   <= '0;
            r_mode_q <= 1'b0;
            r_out    <= 3'b000;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_mode_q <= auto_mode;
            r_out    <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        if (!power_on) begin
            w_state_nxt = ST_OFF;
        end else if (r_state == ST_OFF) begin
            w_state_nxt = ST_IDLE;
        end else if (w_mode_chg) begin
            w_state_nxt = ST_IDLE;
        end else if (w_sel_brake) begin
            w_state_nxt = ST_BRAKE;
        end else if (w_req_l) begin
            w_state_nxt = ST_LEFT;
            w_hold_nxt  = HOLD_LD;
        end else if (w_req_r) begin
            w_state_nxt = ST_RIGHT;
            w_hold_nxt  = HOLD_LD;
        end else if (w_in_turn && (r_hold != '0)) begin
            // Hold phase: keep blinking until the last tick drains the counter.
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;
            if (tick) begin
                w_hold_nxt = r_hold - HOLD_ONE;
                if (r_hold == HOLD_ONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        w_out_nxt = 3'b000;
        case (w_state_nxt)
            ST_BRAKE: w_out_nxt = 3'b100;
            ST_LEFT:  w_out_nxt = 3'b010;
            ST_RIGHT: w_out_nxt = 3'b001;
            default:  w_out_nxt = 3'b000;
        endcase
    end

    assign stay          = r_out[2];
    assign twinkle_left  = r_out[1];
    assign twinkle_right = r_out[0];
    assign state_o       = r_state;

endmodule
